// File: rtl/fir_stim_gen.sv
// Programmable test-sample source feeding the FIR filter: sine (quarter-wave ROM),
// impulse, step or PRBS-8, emitted as a one-cycle strobe every i_div+1 clocks.
module fir_stim_gen #(
  parameter int unsigned WW_OUTPUT = 8,
  parameter int unsigned WW_PHASE  = 16,
  parameter int unsigned WW_DIV    = 16
) (
  input  logic                        clk,
  input  logic                        i_srst,
  input  logic                        i_run,
  input  logic [1:0]                  i_mode,
  input  logic [WW_DIV-1:0]           i_div,
  input  logic [WW_PHASE-1:0]         i_fcw,
  input  logic [2:0]                  i_shift,
  output logic signed [WW_OUTPUT-1:0] o_data,
  output logic                        o_en
);

  localparam int unsigned LSH = WW_OUTPUT - 8;

  typedef enum logic [1:0] {
    MODE_SINE    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_STEP    = 2'd2,
    MODE_PRBS    = 2'd3
  } mode_e;

  // First quadrant of a 127-amplitude sine, sampled at bin centres
  localparam logic [6:0] SINE_ROM [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic                        run_q;
  mode_e                       mode_q, mode_d;
  logic [WW_DIV-1:0]           cnt_q, cnt_d;
  logic [WW_PHASE-1:0]         phase_q, phase_d;
  logic [7:0]                  lfsr_q, lfsr_d;
  logic                        imp_done_q, imp_done_d;
  logic                        tick;

  logic                        s1_vld_q, s1_vld_d;
  logic                        s1_sine_q, s1_sine_d;
  logic [7:0]                  s1_addr_q, s1_addr_d;
  logic signed [7:0]           s1_raw_q, s1_raw_d;
  logic [2:0]                  s1_shift_q, s1_shift_d;

  logic                        s2_vld_q, s2_vld_d;
  logic signed [7:0]           s2_samp_q, s2_samp_d;
  logic [2:0]                  s2_shift_q, s2_shift_d;

  logic                        o_en_q, o_en_d;
  logic signed [WW_OUTPUT-1:0] o_data_q, o_data_d;

  logic [5:0]                  rom_idx;
  logic signed [7:0]           sine_mag;
  logic signed [7:0]           shifted;

  // Divider, phase accumulator, LFSR and mode latch
  always_comb begin
    tick       = run_q && (cnt_q >= i_div);
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    lfsr_d     = lfsr_q;
    imp_done_d = imp_done_q;

    if (i_run && !run_q) begin
      mode_d = mode_e'(i_mode);
    end

    if (!i_run) begin
      cnt_d      = '0;
      phase_d    = '0;
      lfsr_d     = 8'h01;
      imp_done_d = 1'b0;
    end else if (tick) begin
      cnt_d      = '0;
      phase_d    = phase_q + i_fcw;
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      imp_done_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // S1: capture sine address or the raw non-sine sample
  always_comb begin
    s1_vld_d   = tick && i_run;
    s1_sine_d  = (mode_q == MODE_SINE);
    s1_addr_d  = phase_q[WW_PHASE-1 -: 8];
    s1_shift_d = i_shift;
    s1_raw_d   = '0;
    case (mode_q)
      MODE_IMPULSE: s1_raw_d = imp_done_q ? 8'sd0 : 8'sd127;
      MODE_STEP:    s1_raw_d = 8'sd127;
      MODE_PRBS:    s1_raw_d = signed'(lfsr_q);
      default:      s1_raw_d = '0;
    endcase
  end

  // S2: quadrant-mirrored ROM read and sign
  always_comb begin
    rom_idx    = s1_addr_q[6] ? ~s1_addr_q[5:0] : s1_addr_q[5:0];
    sine_mag   = signed'({1'b0, SINE_ROM[rom_idx]});
    s2_vld_d   = s1_vld_q && i_run;
    s2_shift_d = s1_shift_q;
    s2_samp_d  = s1_raw_q;
    if (s1_sine_q) begin
      s2_samp_d = s1_addr_q[7] ? -sine_mag : sine_mag;
    end
  end

  // S3: attenuate, sign-extend and align to the top of the output word
  always_comb begin
    shifted  = s2_samp_q >>> s2_shift_q;
    o_en_d   = s2_vld_q && i_run;
    o_data_d = o_data_q;
    if (o_en_d) begin
      o_data_d = WW_OUTPUT'(shifted) <<< LSH;
    end
  end

  always_ff @(posedge clk or posedge i_srst) begin
    if (i_srst) begin
      run_q      <= 1'b0;
      mode_q     <= MODE_SINE;
      cnt_q      <= '0;
      phase_q    <= '0;
      lfsr_q     <= 8'h01;
      imp_done_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_sine_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_raw_q   <= '0;
      s1_shift_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_samp_q  <= '0;
      s2_shift_q <= '0;
      o_en_q     <= 1'b0;
      o_data_q   <= '0;
    end else begin
      run_q      <= i_run;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      lfsr_q     <= lfsr_d;
      imp_done_q <= imp_done_d;
      s1_vld_q   <= s1_vld_d;
      s1_sine_q  <= s1_sine_d;
      s1_addr_q  <= s1_addr_d;
      s1_raw_q   <= s1_raw_d;
      s1_shift_q <= s1_shift_d;
      s2_vld_q   <= s2_vld_d;
      s2_samp_q  <= s2_samp_d;
      s2_shift_q <= s2_shift_d;
      o_en_q     <= o_en_d;
      o_data_q   <= o_data_d;
    end
  end

  assign o_en   = o_en_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Bench for fir_stim_gen: 8-bit and 12-bit instances share stimulus and are checked
// against an arithmetic model of tick timing and waveform values.
module tb_fir_stim_gen;

  localparam real PI = 3.14159265358979;

  logic              clk;
  logic              i_srst;
  logic              i_run;
  logic [1:0]        i_mode;
  logic [15:0]       i_div;
  logic [15:0]       i_fcw;
  logic [2:0]        i_shift;
  logic signed [7:0]  data8;
  logic signed [11:0] data12;
  logic              en8;
  logic              en12;

  int n_tests;
  int n_fail;
  int last8;

  typedef struct {
    int mode;
    int div;
    int fcw;
    int shift;
    int idx;
    int exp8;
  } vec_t;

  vec_t tbl [16];

  fir_stim_gen #(.WW_OUTPUT(8), .WW_PHASE(16), .WW_DIV(16)) dut8 (
    .clk(clk), .i_srst(i_srst), .i_run(i_run), .i_mode(i_mode), .i_div(i_div),
    .i_fcw(i_fcw), .i_shift(i_shift), .o_data(data8), .o_en(en8)
  );

  fir_stim_gen #(.WW_OUTPUT(12), .WW_PHASE(16), .WW_DIV(16)) dut12 (
    .clk(clk), .i_srst(i_srst), .i_run(i_run), .i_mode(i_mode), .i_div(i_div),
    .i_fcw(i_fcw), .i_shift(i_shift), .o_data(data12), .o_en(en12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Sample number m (0-based) since run start, as an 8-bit signed value
  function automatic int raw_sample(input int mode, input int m, input int fcw);
    int ph;
    int a;
    int l;
    case (mode)
      0: begin
        ph = (m * fcw) % 65536;
        a  = ph / 256;
        return rnd(127.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 256.0));
      end
      1: return (m == 0) ? 127 : 0;
      2: return 127;
      default: begin
        l = 1;
        for (int i = 0; i < m; i++) begin
          l = ((l * 2) % 256) + (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1);
        end
        return (l > 127) ? l - 256 : l;
      end
    endcase
  endfunction

  function automatic int scale8(input int raw, input int sh);
    return raw >>> sh;
  endfunction

  task automatic chk_cycle(input string tag, input logic en_exp);
    chk({tag, " en8"}, en8, en_exp);
    chk({tag, " en12"}, en12, en_exp);
    chk({tag, " data8"}, data8, last8);
    chk({tag, " data12"}, data12, last8 * 16);
  endtask

  task automatic idle(input int n);
    i_run = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      chk_cycle("idle", 1'b0);
    end
  endtask

  // Run from a fresh start with constant settings, checking every cycle
  task automatic run_check(input int mode, input int div, input int fcw,
                           input int sh, input int ncyc);
    int   rel;
    logic en_exp;
    i_mode  = 2'(mode);
    i_div   = 16'(div);
    i_fcw   = 16'(fcw);
    i_shift = 3'(sh);
    i_run   = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      step();
      i_mode = 2'($urandom);
      rel    = k - 3 - div;
      en_exp = (rel >= 0) && ((rel % (div + 1)) == 0);
      if (en_exp) last8 = scale8(raw_sample(mode, rel / (div + 1), fcw), sh);
      chk_cycle("run", en_exp);
    end
  endtask

  initial begin
    int   mode_r;
    int   div_r;
    int   target;
    logic en_exp;

    n_tests = 0;
    n_fail  = 0;
    last8   = 0;
    i_srst  = 1'b1;
    i_run   = 1'b0;
    i_mode  = '0;
    i_div   = '0;
    i_fcw   = '0;
    i_shift = '0;

    tbl[0]  = '{0, 0, 16'h0400, 0, 0,   2};
    tbl[1]  = '{0, 0, 16'h0400, 0, 16,  127};
    tbl[2]  = '{0, 0, 16'h0400, 0, 32,  -2};
    tbl[3]  = '{0, 0, 16'h0400, 0, 48,  -127};
    tbl[4]  = '{0, 0, 16'h0400, 0, 64,  2};
    tbl[5]  = '{0, 0, 16'h0400, 2, 48,  -32};
    tbl[6]  = '{1, 4, 0,        0, 0,   127};
    tbl[7]  = '{1, 4, 0,        0, 1,   0};
    tbl[8]  = '{1, 4, 0,        0, 2,   0};
    tbl[9]  = '{2, 2, 0,        3, 0,   15};
    tbl[10] = '{2, 2, 0,        3, 3,   15};
    tbl[11] = '{3, 0, 0,        0, 0,   1};
    tbl[12] = '{3, 0, 0,        0, 3,   8};
    tbl[13] = '{3, 0, 0,        0, 4,   17};
    tbl[14] = '{3, 0, 0,        0, 255, 1};
    tbl[15] = '{3, 0, 0,        1, 3,   4};

    #12;
    chk_cycle("reset", 1'b0);
    @(negedge clk);
    i_srst = 1'b0;
    idle(2);

    // Table: one named sample per record, landing at cycle div+3+idx*(div+1)
    for (int i = 0; i < 16; i++) begin
      i_mode  = 2'(tbl[i].mode);
      i_div   = 16'(tbl[i].div);
      i_fcw   = 16'(tbl[i].fcw);
      i_shift = 3'(tbl[i].shift);
      i_run   = 1'b1;
      target  = tbl[i].div + 3 + tbl[i].idx * (tbl[i].div + 1);
      for (int k = 0; k <= target; k++) begin
        step();
        i_mode = 2'($urandom);
      end
      chk($sformatf("tbl%0d en8", i), en8, 1'b1);
      chk($sformatf("tbl%0d en12", i), en12, 1'b1);
      chk($sformatf("tbl%0d data8", i), data8, tbl[i].exp8);
      chk($sformatf("tbl%0d data12", i), data12, tbl[i].exp8 * 16);
      last8 = tbl[i].exp8;
      idle(2);
    end

    // Full-cycle checks of each waveform
    run_check(0, 0, 16'h0400, 0, 140);
    idle(2);
    run_check(0, 0, 16'h0100, 0, 263);
    idle(2);
    run_check(1, 4, 0, 0, 40);
    idle(2);
    run_check(2, 3, 0, 3, 30);
    idle(2);
    run_check(3, 0, 0, 0, 270);
    idle(2);

    // Run dropped at, one after, and two after a tick: sample discarded, data held
    run_check(2, 0, 0, 1, 6);
    for (int d = 4; d <= 6; d++) begin
      idle(2);
      i_mode  = 2'd1;
      i_div   = 16'd4;
      i_fcw   = '0;
      i_shift = '0;
      i_run   = 1'b1;
      for (int k = 0; k <= d; k++) begin
        step();
        chk_cycle("drop_pre", 1'b0);
      end
      i_run = 1'b0;
      for (int k = 0; k < 6; k++) begin
        step();
        chk_cycle("drop", 1'b0);
      end
      run_check(1, 4, 0, 0, 20);
    end

    // Divider lowered below the running count
    idle(2);
    i_mode  = 2'd2;
    i_div   = 16'd10;
    i_fcw   = '0;
    i_shift = '0;
    i_run   = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      if (k == 5) i_div = 16'd2;
      en_exp = (k == 8) || (k == 11) || (k == 14);
      if (en_exp) last8 = 127;
      chk_cycle("divlow", en_exp);
    end
    idle(2);

    // Asynchronous reset between edges while running PRBS
    run_check(3, 0, 0, 0, 10);
    #2;
    i_srst = 1'b1;
    #1;
    last8 = 0;
    chk_cycle("async_rst", 1'b0);
    @(negedge clk);
    i_srst = 1'b0;
    run_check(3, 0, 0, 0, 20);
    idle(2);

    // Randomized configurations
    for (int r = 0; r < 8; r++) begin
      mode_r = int'($urandom_range(0, 3));
      div_r  = int'($urandom_range(0, 6));
      run_check(mode_r, div_r, int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 7)), 150);
      idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
